// File: rtl/controller_imem_scrubber_if.sv
// rtl/controller_imem_scrubber_if.sv - host bus and instruction-RAM port bundle for the scrubber
// The slave modport is the scrubber's view; master is the host/RAM environment.
interface controller_imem_scrubber_if #(
  parameter int ADDR_W = 13
);
  logic [ADDR_W-1:0] host_address;
  logic              host_read;
  logic              host_write;
  logic [31:0]       host_writedata;
  logic [3:0]        host_byteenable;
  logic              host_waitrequest;
  logic [31:0]       host_readdata;
  logic              host_readdatavalid;

  logic [ADDR_W-1:0] mem_address;
  logic              mem_chipselect;
  logic              mem_write;
  logic              mem_debugaccess;
  logic [31:0]       mem_writedata;
  logic [3:0]        mem_byteenable;
  logic [31:0]       mem_readdata;

  modport slave (
    input  host_address, host_read, host_write, host_writedata, host_byteenable,
    output host_waitrequest, host_readdata, host_readdatavalid,
    output mem_address, mem_chipselect, mem_write, mem_debugaccess,
    output mem_writedata, mem_byteenable,
    input  mem_readdata
  );

  modport master (
    output host_address, host_read, host_write, host_writedata, host_byteenable,
    input  host_waitrequest, host_readdata, host_readdatavalid,
    input  mem_address, mem_chipselect, mem_write, mem_debugaccess,
    input  mem_writedata, mem_byteenable,
    output mem_readdata
  );
endinterface

// File: rtl/controller_imem_scrubber.sv
// rtl/controller_imem_scrubber.sv - instruction-RAM checksum scrubber sharing the RAM port with a host
// Host has priority on the port; the scanner is forced through after STARVE_LIMIT denials.
module controller_imem_scrubber #(
  parameter int ADDR_W       = 13,
  parameter int STARVE_LIMIT = 8
) (
  input  logic                        clk,
  input  logic                        reset,
  controller_imem_scrubber_if.slave   bus,
  input  logic                        start,
  output logic                        busy,
  output logic                        done,
  output logic [31:0]                 checksum
);
  localparam int SW = $clog2(STARVE_LIMIT + 1) < 1 ? 1 : $clog2(STARVE_LIMIT + 1);
  localparam logic [ADDR_W-1:0] LAST_ADDR = '1;

  typedef enum logic [1:0] {IDLE, SCAN, DRAIN} state_t;

  state_t            state_q, state_d;
  logic [ADDR_W-1:0] scan_addr_q, scan_addr_d;
  logic [SW-1:0]     starve_q, starve_d;
  logic [31:0]       acc_q, acc_d;
  logic [31:0]       checksum_q, checksum_d;
  logic              done_q, done_d;
  logic              rdv_q, rdv_d;
  logic              scan_rd_q, scan_rd_d;

  logic host_req;
  logic host_grant;
  logic scan_issue;

  // Gating with reset keeps the RAM port quiet for the whole time reset is held.
  assign host_req   = bus.host_read | bus.host_write;
  assign host_grant = host_req && !reset &&
                      !((state_q == SCAN) && (starve_q == SW'(STARVE_LIMIT)));
  assign scan_issue = (state_q == SCAN) && !host_grant && !reset;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q     <= IDLE;
      scan_addr_q <= '0;
      starve_q    <= '0;
      acc_q       <= '0;
      checksum_q  <= '0;
      done_q      <= 1'b0;
      rdv_q       <= 1'b0;
      scan_rd_q   <= 1'b0;
    end else begin
      state_q     <= state_d;
      scan_addr_q <= scan_addr_d;
      starve_q    <= starve_d;
      acc_q       <= acc_d;
      checksum_q  <= checksum_d;
      done_q      <= done_d;
      rdv_q       <= rdv_d;
      scan_rd_q   <= scan_rd_d;
    end
  end

  always_comb begin
    state_d     = state_q;
    scan_addr_d = scan_addr_q;
    starve_d    = starve_q;
    checksum_d  = checksum_q;
    done_d      = 1'b0;
    rdv_d       = host_grant && bus.host_read && !bus.host_write;
    scan_rd_d   = scan_issue;
    acc_d       = scan_rd_q ? acc_q + bus.mem_readdata : acc_q;

    case (state_q)
      IDLE: begin
        if (start) state_d = SCAN;
      end
      SCAN: begin
        if (scan_issue) begin
          scan_addr_d = scan_addr_q + ADDR_W'(1);
          starve_d    = '0;
          if (scan_addr_q == LAST_ADDR) state_d = DRAIN;
        end else if (host_grant) begin
          starve_d = starve_q + SW'(1);
        end
      end
      DRAIN: begin
        // The last word's data lands this cycle; fold it straight into the result.
        state_d     = IDLE;
        checksum_d  = acc_q + bus.mem_readdata;
        done_d      = 1'b1;
        acc_d       = '0;
        scan_addr_d = '0;
        starve_d    = '0;
      end
      default: state_d = IDLE;
    endcase
  end

  always_comb begin
    bus.mem_address     = '0;
    bus.mem_chipselect  = 1'b0;
    bus.mem_write       = 1'b0;
    bus.mem_debugaccess = 1'b0;
    bus.mem_writedata   = '0;
    bus.mem_byteenable  = '0;
    if (host_grant) begin
      bus.mem_address     = bus.host_address;
      bus.mem_chipselect  = 1'b1;
      bus.mem_write       = bus.host_write;
      bus.mem_debugaccess = bus.host_write;
      bus.mem_writedata   = bus.host_writedata;
      bus.mem_byteenable  = bus.host_byteenable;
    end else if (scan_issue) begin
      bus.mem_address     = scan_addr_q;
      bus.mem_chipselect  = 1'b1;
      bus.mem_byteenable  = 4'hF;
    end
  end

  assign bus.host_waitrequest   = host_req && !host_grant;
  assign bus.host_readdata      = bus.mem_readdata;
  assign bus.host_readdatavalid = rdv_q;
  assign busy                   = (state_q != IDLE);
  assign done                   = done_q;
  assign checksum               = checksum_q;
endmodule

// File: tb/tb_controller_imem_scrubber.sv
// tb/tb_controller_imem_scrubber.sv - randomized bench with behavioural port-arbitration and checksum model
// RAM is modelled beside the DUT; the reference model keeps its own shadow copy of memory.
module tb_controller_imem_scrubber;
  localparam int ADDR_W = 13;
  localparam int DEPTH  = 1 << ADDR_W;
  localparam int LIMIT  = 8;

  logic clk;
  logic reset_s;
  logic start_s;
  logic busy, done;
  logic [31:0] checksum;

  logic              hr, hw;
  logic [ADDR_W-1:0] ha;
  logic [31:0]       hwd;
  logic [3:0]        hbe;

  logic [31:0] ram [0:DEPTH-1];
  logic [31:0] ram_q;
  logic        ram_init = 1'b0;

  int n_checks = 0;
  int n_errors = 0;
  int traffic  = 0;

  logic [31:0] shadow [0:DEPTH-1];
  int          m_mode;
  int          m_addr;
  int          m_starve;
  logic [31:0] m_acc, m_chk, m_rd_val;
  logic        m_done, m_rdv;

  controller_imem_scrubber_if #(.ADDR_W(ADDR_W)) bus ();

  assign bus.host_address    = ha;
  assign bus.host_read       = hr;
  assign bus.host_write      = hw;
  assign bus.host_writedata  = hwd;
  assign bus.host_byteenable = hbe;
  assign bus.mem_readdata    = ram_q;

  controller_imem_scrubber #(.ADDR_W(ADDR_W), .STARVE_LIMIT(LIMIT)) dut (
    .clk      (clk),
    .reset    (reset_s),
    .bus      (bus.slave),
    .start    (start_s),
    .busy     (busy),
    .done     (done),
    .checksum (checksum)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Single-port RAM with one-cycle read latency and byte lanes.
  always @(posedge clk) begin
    if (!ram_init) begin
      for (int i = 0; i < DEPTH; i++) ram[i] <= i;
      ram_init <= 1'b1;
    end else if (bus.mem_chipselect) begin
      if (bus.mem_write) begin
        for (int b = 0; b < 4; b++)
          if (bus.mem_byteenable[b]) ram[bus.mem_address][8*b +: 8] <= bus.mem_writedata[8*b +: 8];
      end else begin
        ram_q <= ram[bus.mem_address];
      end
    end
  end

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_errors++;
      if (n_errors <= 40) $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
    end
  endtask

  // Compare this cycle's outputs against the model, then advance the model past the next edge.
  task automatic model_cycle();
    logic req, grant, scan;
    if (reset_s) begin
      m_mode = 0; m_addr = 0; m_starve = 0;
      m_acc = 0; m_chk = 0; m_done = 0; m_rdv = 0;
    end
    req   = hr | hw;
    grant = req && !reset_s && !(m_mode == 1 && m_starve == LIMIT);
    scan  = !reset_s && m_mode == 1 && !grant;

    chk("waitrequest", {31'd0, bus.host_waitrequest}, {31'd0, req && !grant});
    chk("chipselect", {31'd0, bus.mem_chipselect}, {31'd0, grant || scan});
    chk("mem_write", {31'd0, bus.mem_write}, {31'd0, grant && hw});
    if (grant) begin
      chk("mem_address_host", {19'd0, bus.mem_address}, {19'd0, ha});
      chk("debugaccess", {31'd0, bus.mem_debugaccess}, {31'd0, hw});
      if (hw) begin
        chk("writedata", bus.mem_writedata, hwd);
        chk("byteenable", {28'd0, bus.mem_byteenable}, {28'd0, hbe});
      end
    end else if (scan) begin
      chk("mem_address_scan", {19'd0, bus.mem_address}, m_addr);
      chk("scan_byteenable", {28'd0, bus.mem_byteenable}, 32'hF);
    end
    chk("busy", {31'd0, busy}, {31'd0, m_mode != 0});
    chk("done", {31'd0, done}, {31'd0, m_done});
    chk("readdatavalid", {31'd0, bus.host_readdatavalid}, {31'd0, m_rdv});
    if (m_rdv) chk("readdata", bus.host_readdata, m_rd_val);
    chk("checksum", checksum, m_chk);

    if (!reset_s) begin
      m_done = 0;
      m_rdv  = grant && hr && !hw;
      if (m_rdv) m_rd_val = shadow[ha];
      if (grant && hw)
        for (int b = 0; b < 4; b++)
          if (hbe[b]) shadow[ha][8*b +: 8] = hwd[8*b +: 8];
      case (m_mode)
        0: if (start_s) m_mode = 1;
        1: begin
          if (scan) begin
            m_acc    = m_acc + shadow[m_addr];
            m_starve = 0;
            if (m_addr == DEPTH - 1) m_mode = 2;
            m_addr = (m_addr + 1) % DEPTH;
          end else if (grant) begin
            m_starve++;
          end
        end
        default: begin
          m_chk  = m_acc;
          m_acc  = 0;
          m_done = 1;
          m_mode = 0;
        end
      endcase
    end
  endtask

  task automatic drive();
    int r;
    @(posedge clk);
    #1;
    hr = 1'b0; hw = 1'b0; start_s = 1'b0;
    ha  = ADDR_W'($urandom);
    hwd = $urandom;
    hbe = 4'($urandom);
    case (traffic)
      1: hr = 1'b1;
      2: hr = 1'($urandom_range(0, 1));
      3: begin
        r = $urandom_range(0, 9);
        if (r < 2) hr = 1'b1;
        else if (r < 3) hw = 1'b1;
        else if (r == 3) begin hr = 1'b1; hw = 1'b1; end
      end
      default: ;
    endcase
  endtask

  task automatic settle();
    @(negedge clk);
    model_cycle();
  endtask

  task automatic step();
    drive();
    settle();
  endtask

  task automatic wait_done(input int limit, output int busy_n, output int done_n);
    busy_n = 0;
    done_n = 0;
    for (int i = 0; i < limit; i++) begin
      step();
      if (busy) busy_n++;
      if (done) begin done_n++; break; end
    end
    chk("scan_completes", {31'd0, done_n != 0}, 32'd1);
    for (int i = 0; i < 5; i++) begin
      step();
      if (done) done_n++;
    end
  endtask

  initial begin
    int busy_n, done_n, wait_n;
    reset_s = 1'b1; start_s = 1'b0;
    hr = 1'b0; hw = 1'b0; ha = '0; hwd = '0; hbe = '0;
    ram_q = '0;
    for (int i = 0; i < DEPTH; i++) shadow[i] = i;
    for (int i = 0; i < 3; i++) step();
    drive(); reset_s = 1'b0; settle();

    // Host read in IDLE
    drive(); hr = 1'b1; ha = 13'h1ABC; settle();
    chk("idle_read_wait", {31'd0, bus.host_waitrequest}, 32'd0);
    step();
    chk("idle_read_valid", {31'd0, bus.host_readdatavalid}, 32'd1);
    chk("idle_read_data", bus.host_readdata, 32'h00001ABC);

    // Quiet scan
    drive(); start_s = 1'b1; settle();
    wait_done(9000, busy_n, done_n);
    chk("scan1_busy_cycles", busy_n, 32'd8193);
    chk("scan1_done_pulses", done_n, 32'd1);
    chk("scan1_checksum", checksum, 32'h01FFF000);

    // Early write to word 5
    drive(); start_s = 1'b1; settle();
    drive(); hw = 1'b1; ha = 13'd5; hwd = 32'h100; hbe = 4'hF; settle();
    wait_done(9000, busy_n, done_n);
    chk("scan2_checksum", checksum, 32'h01FFF0FB);

    // Saturating host reads, a stray start, then a late write to word 5
    drive(); start_s = 1'b1; settle();
    traffic = 1;
    wait_n = 0;
    for (int i = 0; i < 900; i++) begin
      drive();
      if (i == 450) start_s = 1'b1;
      settle();
      if (bus.host_waitrequest) wait_n++;
    end
    chk("starve_wait_cycles", wait_n, 32'd100);
    traffic = 0;
    drive(); hw = 1'b1; ha = 13'd5; hwd = 32'h100; hbe = 4'hF; settle();
    traffic = 2;
    wait_done(30000, busy_n, done_n);
    traffic = 0;
    chk("scan3_checksum", checksum, 32'h01FFF0FB);
    chk("scan3_done_pulses", done_n, 32'd1);

    // Reset mid-scan at scan_addr 0x800, then restart under mixed traffic
    drive(); start_s = 1'b1; settle();
    for (int i = 0; i < 2048; i++) step();
    drive(); reset_s = 1'b1; settle();
    chk("reset_busy", {31'd0, busy}, 32'd0);
    chk("reset_checksum", checksum, 32'd0);
    chk("reset_done", {31'd0, done}, 32'd0);
    step();
    drive(); reset_s = 1'b0; settle();
    chk("post_reset_done", {31'd0, done}, 32'd0);
    drive(); start_s = 1'b1; settle();
    step();
    chk("restart_addr", {19'd0, bus.mem_address}, 32'd0);
    chk("restart_cs", {31'd0, bus.mem_chipselect}, 32'd1);
    traffic = 3;
    wait_done(30000, busy_n, done_n);
    traffic = 0;
    chk("scan4_done_pulses", done_n, 32'd1);

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end
endmodule
